command_sequencer: RTL and testbench

COMMAND_SEQUENCER -- requirements
Module: command_sequencer

---
 rtl/command_sequencer_pkg.sv | 34 +++
 rtl/command_sequencer_delay_line.sv | 54 +++++
 rtl/command_sequencer.sv | 156 +++++++++++++++
 tb/tb_command_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/command_sequencer_pkg.sv
// Shared definitions for the command sequencer: opcode constants, command word
// field layout, FSM state encoding and a small opcode classification helper.
package command_sequencer_pkg;

    // Command word layout
    localparam int unsigned CmdW     = 40;
    localparam int unsigned OpLsb    = 0;
    localparam int unsigned OpW      = 5;
    localparam int unsigned SrcLsb   = 5;
    localparam int unsigned DstLsb   = 9;
    localparam int unsigned BankW    = 4;
    localparam int unsigned CntLsb   = 13;
    localparam int unsigned CntW     = 11;
    localparam int unsigned ParamLsb = 24;
    localparam int unsigned ParamW   = 16;

    // Non-instruction opcodes
    localparam logic [OpW-1:0] OP_NOP = 5'd0;
    localparam logic [OpW-1:0] OP_END = 5'd31;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRead,
        StDrain,
        StDone
    } seq_state_e;

    // True for opcodes that start a transfer.
    function automatic logic is_compute(input logic [OpW-1:0] op);
        return (op != OP_NOP) && (op != OP_END);
    endfunction

endpackage

// File: rtl/command_sequencer_delay_line.sv
// seq_delay_line: Depth-stage shift register carrying a valid bit and an address,
// used to turn read strobes into write strobes a fixed number of cycles later.
//   clk_i       clock
//   rst_ni      asynchronous active-low reset, clears every stage
//   valid_i     strobe entering stage 0
//   addr_i      address entering stage 0
//   valid_o     strobe leaving the last stage
//   addr_o      address leaving the last stage
//   inflight_o  any valid entry in stages other than the last one
module seq_delay_line #(
    parameter int unsigned Depth = 4,
    parameter int unsigned AddrW = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [AddrW-1:0] addr_i,
    output logic             valid_o,
    output logic [AddrW-1:0] addr_o,
    output logic             inflight_o
);

    logic [Depth-1:0] valid_q;
    logic [AddrW-1:0] addr_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            addr_q[0]  <= addr_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    // The last stage is excluded: its entry is being written out this cycle, so
    // the line is empty after this edge when the earlier stages are empty.
    always_comb begin
        inflight_o = 1'b0;
        for (int unsigned i = 0; i + 1 < Depth; i++) begin
            inflight_o = inflight_o | valid_q[i];
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign addr_o  = addr_q[Depth-1];

endmodule

// File: rtl/command_sequencer.sv
// command_sequencer: accepts level-held command words, walks a source bank with
// read strobes and issues matching writes to a destination bank PIPE_LAT cycles
// later, then pulses done.
//   clk, rst_n              clock, asynchronous active-low reset
//   command_in, command_we  command word and its level-valid
//   done_ins_computation    one-cycle completion pulse
//   busy                    command in progress
//   rd_en/rd_bank/rd_addr   source read strobe, bank, address
//   wr_en/wr_bank/wr_addr   destination write strobe, bank, address
//   op_code/op_param        latched opcode and param for the datapath
//   err_overrun             sticky: new command seen while busy
module command_sequencer
    import command_sequencer_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CmdW-1:0]   command_in,
    input  logic              command_we,
    output logic              done_ins_computation,
    output logic              busy,
    output logic              rd_en,
    output logic [BankW-1:0]  rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [BankW-1:0]  wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [OpW-1:0]    op_code,
    output logic [ParamW-1:0] op_param,
    output logic              err_overrun
);

    seq_state_e state_q, state_d;

    logic              prev_we_q;
    logic [CmdW-1:0]   last_word_q;
    logic              pending_q, pending_d;
    logic              accept_evt, retry_ok, cmd_is_op, start, last_elem;

    logic [CntW-1:0]   cnt_q, cnt_m1_q;
    logic [BankW-1:0]  src_q, dst_q;
    logic [OpW-1:0]    op_q;
    logic [ParamW-1:0] param_q;
    logic              err_q;

    logic              dl_valid, dl_inflight;
    logic [ADDR_W-1:0] dl_addr;
    logic [ADDR_W-1:0] rd_addr_int;

    // Acceptance: rising command_we, or a changed word while it stays high.
    assign accept_evt = command_we && (!prev_we_q || (command_in != last_word_q));
    assign cmd_is_op  = is_compute(command_in[OpLsb +: OpW]);
    // A word that arrived during DONE is picked up here if it is still presented.
    assign retry_ok   = pending_q && command_we && (command_in == last_word_q);
    assign start      = (state_q == StIdle) && (accept_evt || retry_ok) && cmd_is_op;
    assign last_elem  = (cnt_q == cnt_m1_q);
    assign pending_d  = (state_q == StDone) && accept_evt && cmd_is_op;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StRead;
            StRead:  if (last_elem) state_d = StDrain;
            StDrain: if (!dl_inflight) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        rd_en                = (state_q == StRead);
        done_ins_computation = (state_q == StDone);
        busy                 = (state_q == StLoad) || (state_q == StRead) ||
                               (state_q == StDrain);
        rd_addr_int          = rd_en ? ADDR_W'(cnt_q) : '0;
    end

    // Command-valid history and acceptance bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_we_q   <= 1'b0;
            last_word_q <= '0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_we_q <= command_we;
            pending_q <= pending_d;
            if (accept_evt) begin
                last_word_q <= command_in;
            end
            if (accept_evt && busy) begin
                err_q <= 1'b1;
            end
        end
    end

    // Latched command fields and element counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cnt_m1_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            op_q     <= '0;
            param_q  <= '0;
        end else if (start) begin
            cnt_q    <= '0;
            cnt_m1_q <= command_in[CntLsb +: CntW];
            src_q    <= command_in[SrcLsb +: BankW];
            dst_q    <= command_in[DstLsb +: BankW];
            op_q     <= command_in[OpLsb +: OpW];
            param_q  <= command_in[ParamLsb +: ParamW];
        end else if (state_q == StLoad) begin
            cnt_q <= '0;
        end else if ((state_q == StRead) && !last_elem) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    seq_delay_line #(
        .Depth (PIPE_LAT),
        .AddrW (ADDR_W)
    ) u_delay_line (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (rd_en),
        .addr_i     (rd_addr_int),
        .valid_o    (dl_valid),
        .addr_o     (dl_addr),
        .inflight_o (dl_inflight)
    );

    assign rd_addr     = rd_addr_int;
    assign rd_bank     = src_q;
    assign wr_en       = dl_valid;
    assign wr_addr     = dl_addr;
    assign wr_bank     = dst_q;
    assign op_code     = op_q;
    assign op_param    = param_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_command_sequencer.sv
module tb_command_sequencer;

    localparam int PL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] command_in;
    logic        command_we;
    logic        done_ins_computation, busy, rd_en, wr_en, err_overrun;
    logic [3:0]  rd_bank, wr_bank;
    logic [10:0] rd_addr, wr_addr;
    logic [4:0]  op_code;
    logic [15:0] op_param;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    command_sequencer #(
        .PIPE_LAT (PL),
        .ADDR_W   (11)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .command_in           (command_in),
        .command_we           (command_we),
        .done_ins_computation (done_ins_computation),
        .busy                 (busy),
        .rd_en                (rd_en),
        .rd_bank              (rd_bank),
        .rd_addr              (rd_addr),
        .wr_en                (wr_en),
        .wr_bank              (wr_bank),
        .wr_addr              (wr_addr),
        .op_code              (op_code),
        .op_param             (op_param),
        .err_overrun          (err_overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] mk(input logic [4:0] op, input logic [3:0] src,
                                       input logic [3:0] dst, input logic [10:0] cm1,
                                       input logic [15:0] prm);
        return {prm, cm1, dst, src, op};
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " done"}, done_ins_computation, 0);
        check_eq({tag, " rd_en"}, rd_en, 0);
        check_eq({tag, " wr_en"}, wr_en, 0);
        check_eq({tag, " err"}, err_overrun, 0);
        check_eq({tag, " rd_addr"}, rd_addr, 0);
        check_eq({tag, " wr_addr"}, wr_addr, 0);
        check_eq({tag, " rd_bank"}, rd_bank, 0);
        check_eq({tag, " wr_bank"}, wr_bank, 0);
        check_eq({tag, " op_code"}, op_code, 0);
        check_eq({tag, " op_param"}, op_param, 0);
    endtask

    task automatic idle_gap();
        command_we = 1'b0;
        command_in = '0;
        step();
    endtask

    // Presents word in the current cycle (cycle 0) and checks every following cycle
    // against the documented timeline: LOAD at 1+off, reads at 2+off.., writes PL
    // later, done at N+PL+2+off. off=1 models a word first seen during DONE.
    task automatic run_check(input string tag, input logic [39:0] word, input int off,
                             input bit stop_at_done, input int alt_k,
                             input logic [39:0] alt_word, input int rst_k);
        int n, done_k, last_k;
        logic [3:0] src, dst;
        logic [4:0] op;
        logic [15:0] prm;
        bit exp_rd, exp_wr, aborted;
        n      = int'(word[23:13]) + 1;
        src    = word[8:5];
        dst    = word[12:9];
        op     = word[4:0];
        prm    = word[39:24];
        done_k = n + PL + 2 + off;
        last_k = stop_at_done ? done_k : done_k + 1;
        command_in = word;
        command_we = 1'b1;
        aborted = 1'b0;
        for (int k = 1; k <= last_k && !aborted; k++) begin
            step();
            exp_rd = (k >= 2 + off) && (k <= n + 1 + off);
            exp_wr = (k >= 2 + off + PL) && (k <= n + 1 + off + PL);
            check_eq($sformatf("%s k%0d rd_en", tag, k), rd_en, exp_rd);
            if (exp_rd) begin
                check_eq($sformatf("%s k%0d rd_addr", tag, k), rd_addr, k - 2 - off);
                check_eq($sformatf("%s k%0d rd_bank", tag, k), rd_bank, src);
            end
            check_eq($sformatf("%s k%0d wr_en", tag, k), wr_en, exp_wr);
            if (exp_wr) begin
                check_eq($sformatf("%s k%0d wr_addr", tag, k), wr_addr, k - 2 - off - PL);
                check_eq($sformatf("%s k%0d wr_bank", tag, k), wr_bank, dst);
            end
            check_eq($sformatf("%s k%0d done", tag, k), done_ins_computation, k == done_k);
            if (k != done_k) begin
                check_eq($sformatf("%s k%0d busy", tag, k), busy,
                         (k >= 1 + off) && (k <= n + PL + 1 + off));
            end
            if ((k >= 1 + off) && (k < done_k)) begin
                check_eq($sformatf("%s k%0d op_code", tag, k), op_code, op);
                check_eq($sformatf("%s k%0d op_param", tag, k), op_param, prm);
            end
            if (k == alt_k) command_in = alt_word;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, " async rst"});
                command_we = 1'b0;
                command_in = '0;
                #1;
                rst_n = 1'b1;
                for (int j = 1; j <= 8; j++) begin
                    step();
                    check_eq($sformatf("%s post-rst%0d done", tag, j), done_ins_computation, 0);
                    check_eq($sformatf("%s post-rst%0d wr_en", tag, j), wr_en, 0);
                    check_eq($sformatf("%s post-rst%0d busy", tag, j), busy, 0);
                end
                aborted = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        command_we = 1'b0;
        command_in = '0;
        #1;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic transfer: 8 elements, src 2 -> dst 5
        run_check("t031", mk(5'd3, 4'd2, 4'd5, 11'd7, 16'hABCD), 0, 1'b0, 0, '0, 0);
        check_eq("t031 err", err_overrun, 0);
        idle_gap();

        // Single element
        run_check("t032", mk(5'd9, 4'd1, 4'd14, 11'd0, 16'h1234), 0, 1'b0, 0, '0, 0);
        idle_gap();

        // Non-instructions
        command_we = 1'b1;
        command_in = mk(5'd0, 4'd2, 4'd3, 11'd5, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t033 nop busy", busy, 0);
            check_eq("t033 nop rd_en", rd_en, 0);
            check_eq("t033 nop done", done_ins_computation, 0);
        end
        command_in = mk(5'd31, 4'd4, 4'd6, 11'd9, 16'h00FF);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t033 end busy", busy, 0);
            check_eq("t033 end rd_en", rd_en, 0);
            check_eq("t033 end done", done_ins_computation, 0);
        end
        idle_gap();

        // Overrun mid-READ; running command unaffected, second never starts
        run_check("t034", mk(5'd3, 4'd2, 4'd5, 11'd7, 16'h5555), 0, 1'b0, 4,
                  mk(5'd6, 4'd1, 4'd1, 11'd3, 16'h7777), 0);
        check_eq("t034 err", err_overrun, 1);
        step();
        check_eq("t034 no restart busy", busy, 0);
        check_eq("t034 no restart rd_en", rd_en, 0);
        idle_gap();
        check_eq("t034 err sticky", err_overrun, 1);

        // Reset during DRAIN (cycles 10..13 for 8 elements), then a fresh command
        run_check("t035", mk(5'd3, 4'd2, 4'd5, 11'd7, 16'h2222), 0, 1'b0, 0, '0, 11);
        run_check("t035b", mk(5'd2, 4'd3, 4'd4, 11'd2, 16'h3333), 0, 1'b0, 0, '0, 0);
        idle_gap();

        // command_we held across two different words
        run_check("t036a", mk(5'd4, 4'd1, 4'd3, 11'd2, 16'h4444), 0, 1'b0, 0, '0, 0);
        run_check("t036b", mk(5'd5, 4'd6, 4'd7, 11'd1, 16'h6666), 0, 1'b0, 0, '0, 0);
        // Word changes in the DONE cycle: started from the following IDLE cycle
        run_check("t026a", mk(5'd7, 4'd8, 4'd9, 11'd3, 16'h8888), 0, 1'b1, 0, '0, 0);
        run_check("t026b", mk(5'd8, 4'd10, 4'd11, 11'd1, 16'h9999), 1, 1'b0, 0, '0, 0);
        check_eq("t036 err", err_overrun, 0);
        idle_gap();

        // Largest command: 2048 elements, addresses 0..2047
        run_check("tmax", mk(5'd1, 4'd15, 4'd0, 11'd2047, 16'hFFFF), 0, 1'b0, 0, '0, 0);
        idle_gap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
